// File: rtl/rank_pkg.sv
// Shared state encoding and rank helpers for rank_filter and its bench.
package rank_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} rank_state_t;

  // Cycles from frame start to result strobe for a frame of n samples at rank k.
  function automatic int unsigned rank_latency(int unsigned n, int unsigned k);
    return (k + 1) * n - 1;
  endfunction

  function automatic int unsigned rank_clamp(int unsigned rank, int unsigned n);
    return (rank >= n) ? n - 1 : rank;
  endfunction

endpackage

// File: rtl/rank_cas.sv
// Combinational unsigned compare-and-swap: hi gets the larger input, lo the smaller.
module rank_cas #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  always_comb begin
    if (a > b) begin
      hi = a;
      lo = b;
    end else begin
      hi = b;
      lo = a;
    end
  end

endmodule

// File: rtl/rank_filter.sv
// Rank-order filter: loads N samples into a shift chain and extracts the sample of
// run-time rank RANK (0 = max) with repeated max-finding passes over one shared CAS.
module rank_filter
  import rank_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned N     = 9,
  localparam int unsigned RW    = $clog2(N)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  input  logic [RW-1:0]    RANK,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  output logic             BUSY
);

  rank_state_t      state_q;
  logic [WIDTH-1:0] r_q [N];
  logic [RW-1:0]    k_q;
  logic [RW-1:0]    pass_q;
  logic [RW-1:0]    step_q;
  logic [RW-1:0]    k_d;
  logic [WIDTH-1:0] do_q;
  logic             dso_q;
  logic             busy_q;
  logic [WIDTH-1:0] cas_hi;
  logic [WIDTH-1:0] cas_lo;
  logic             drop_step;
  logic             last_cmp;

  assign k_d = RW'(rank_clamp(32'(RANK), N));

  // Steps 0..N-2 of a pass are compares; step N-1 is the drop before the next pass.
  assign drop_step = (step_q == RW'(N - 1));
  assign last_cmp  = (step_q == RW'(N - 2)) && (pass_q == k_q);

  rank_cas #(
    .WIDTH(WIDTH)
  ) u_cas (
    .a (r_q[N-2]),
    .b (r_q[N-1]),
    .hi(cas_hi),
    .lo(cas_lo)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < N; i++) r_q[i] <= '0;
      k_q     <= '0;
      pass_q  <= '0;
      step_q  <= '0;
      do_q    <= '0;
      dso_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      dso_q <= 1'b0;
      unique case (state_q)
        IDLE, LOAD, DONE: begin
          if (DSI) begin
            for (int unsigned i = 1; i < N; i++) r_q[i] <= r_q[i-1];
            r_q[0]  <= DI;
            state_q <= LOAD;
          end else if (state_q == LOAD) begin
            k_q     <= k_d;
            pass_q  <= '0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (DSI) begin
            for (int unsigned i = 1; i < N; i++) r_q[i] <= r_q[i-1];
            r_q[0]  <= DI;
            busy_q  <= 1'b0;
            state_q <= LOAD;
          end else if (drop_step) begin
            // Drop discards the current maximum by shifting a zero in at the head.
            for (int unsigned i = 1; i < N; i++) r_q[i] <= r_q[i-1];
            r_q[0] <= '0;
            step_q <= '0;
            pass_q <= pass_q + 1'b1;
          end else begin
            for (int unsigned i = 1; i < N - 1; i++) r_q[i] <= r_q[i-1];
            r_q[N-1] <= cas_hi;
            r_q[0]   <= cas_lo;
            if (last_cmp) begin
              do_q    <= cas_hi;
              dso_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign DO   = do_q;
  assign DSO  = dso_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_rank_filter.sv
// Scoreboard bench for rank_filter: directed frames on a 9x8-bit instance and
// randomised frames on a 5x12-bit instance checked against a sorting reference.
module tb_rank_filter;
  import rank_pkg::*;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  di_a;
  logic [7:0]  do_a;
  logic        dsi_a;
  logic        dso_a;
  logic        busy_a;
  logic [3:0]  rank_a;
  logic [11:0] di_b;
  logic [11:0] do_b;
  logic        dsi_b;
  logic        dso_b;
  logic        busy_b;
  logic [2:0]  rank_b;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  int   smp[$];
  bit   prev_a = 1'b0;
  bit   prev_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rank_filter #(.WIDTH(8), .N(9)) dut_a (
    .CLK (clk),
    .nRST(rst_n),
    .DI  (di_a),
    .DSI (dsi_a),
    .RANK(rank_a),
    .DO  (do_a),
    .DSO (dso_a),
    .BUSY(busy_a)
  );

  rank_filter #(.WIDTH(12), .N(5)) dut_b (
    .CLK (clk),
    .nRST(rst_n),
    .DI  (di_b),
    .DSI (dsi_b),
    .RANK(rank_b),
    .DO  (do_b),
    .DSO (dso_b),
    .BUSY(busy_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dso_a) begin
      chk("dso_a_single", int'(prev_a), 0);
      chk("dso_a_expected", int'(sb_a.size() != 0), 1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        chk("do_a", int'(do_a), e.val);
        chk("lat_a", cyc, e.cyc);
        chk("busy_a_done", int'(busy_a), 0);
      end
    end
    prev_a = dso_a;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dso_b) begin
      chk("dso_b_single", int'(prev_b), 0);
      chk("dso_b_expected", int'(sb_b.size() != 0), 1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        chk("do_b", int'(do_b), e.val);
        chk("lat_b", cyc, e.cyc);
        chk("busy_b_done", int'(busy_b), 0);
      end
    end
    prev_b = dso_b;
  end

  task automatic drain(input bit which, input int budget);
    int n = 0;
    while (((which ? sb_b.size() : sb_a.size()) != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(which ? "drain_b" : "drain_a", which ? sb_b.size() : sb_a.size(), 0);
    if (which) sb_b.delete();
    else sb_a.delete();
  endtask

  task automatic load_a(input int rank, output int c);
    foreach (smp[i]) begin
      di_a  = 8'(smp[i]);
      dsi_a = 1'b1;
      @(posedge clk);
      #1;
    end
    dsi_a  = 1'b0;
    rank_a = 4'(rank);
    c      = cyc;
  endtask

  task automatic send_a(input int rank, input int exp_val, input int lat);
    int   c;
    exp_t e;
    load_a(rank, c);
    e.val = exp_val;
    e.cyc = c + 1 + lat;
    sb_a.push_back(e);
    @(posedge clk);
    #1;
    rank_a = 4'($urandom_range(0, 15));
    drain(1'b0, lat + 20);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #950_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c;
    exp_t e;
    di_a = '0; dsi_a = 1'b0; rank_a = '0;
    di_b = '0; dsi_b = 1'b0; rank_b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_do_a", int'(do_a), 0);
    chk("rst_dso_a", int'(dso_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_do_b", int'(do_b), 0);
    chk("rst_dso_b", int'(dso_b), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    smp = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    send_a(4, 5, 44);
    send_a(0, 9, 8);
    send_a(8, 1, 80);
    send_a(13, 1, 80);
    send_a(2, 7, 26);

    smp = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20};
    send_a(4, 16, 44);

    smp = '{200, 200, 200, 200, 200, 200, 200, 200, 0};
    send_a(8, 0, 80);
    send_a(4, 200, 44);

    // Abort: new frame's first strobe lands on the 10th RUN edge.
    smp = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    load_a(4, c);
    @(posedge clk);
    #1;
    rank_a = 4'd0;
    repeat (9) @(posedge clk);
    #1;
    chk("busy_a_run", int'(busy_a), 1);
    smp = '{50, 40, 30, 20, 10, 60, 70, 80, 90};
    load_a(0, c);
    chk("do_a_abort_hold", int'(do_a), 200);
    e.val = 90;
    e.cyc = c + 1 + 8;
    sb_a.push_back(e);
    @(posedge clk);
    #1;
    drain(1'b0, 40);
    @(posedge clk);
    #1;

    // Reset in the middle of a running frame.
    smp = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    load_a(4, c);
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_do_a", int'(do_a), 0);
    chk("mid_rst_dso_a", int'(dso_a), 0);
    chk("mid_rst_busy_a", int'(busy_a), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    smp = '{5, 5, 5, 1, 2, 3, 4, 6, 7};
    send_a(6, 3, 62);

    for (int f = 0; f < 1000; f++) begin
      int ns;
      int r;
      int k;
      int t;
      int s[7];
      int w[5];
      ns = int'($urandom_range(5, 7));
      for (int i = 0; i < ns; i++)
        s[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                           : int'($urandom_range(0, 4095));
      r = int'($urandom_range(0, 7));
      k = (r >= 5) ? 4 : r;
      for (int i = 0; i < 5; i++) w[i] = s[ns - 5 + i];
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4 - i; j++)
          if (w[j] < w[j+1]) begin
            t      = w[j];
            w[j]   = w[j+1];
            w[j+1] = t;
          end
      for (int i = 0; i < ns; i++) begin
        di_b  = 12'(s[i]);
        dsi_b = 1'b1;
        @(posedge clk);
        #1;
      end
      dsi_b  = 1'b0;
      rank_b = 3'(r);
      c      = cyc;
      e.val  = w[k];
      e.cyc  = c + 1 + int'(rank_latency(5, k));
      sb_b.push_back(e);
      @(posedge clk);
      #1;
      rank_b = 3'($urandom_range(0, 7));
      drain(1'b1, 60);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_a_left", sb_a.size(), 0);
    chk("sb_b_left", sb_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
